hilo_muldiv_unit: RTL and testbench

- Multicycle multiply/divide unit that owns the HI/LO register pair for the MIPS datapath.
- Executes MULT, MULTU, DIV, DIVU iteratively, one bit per cycle, and performs single-cycle MTHI/MTLO writes.
- HI and LO drive the inputs of the 32-bit 2:1 result-select mux that chooses between them for MFHI/MFLO writeback.
- The hazard unit uses busy to stall the pipeline.

---
 rtl/hilo_muldiv_unit.sv | 209 ++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Iterative multiply/divide unit that owns the MIPS HI/LO register pair.
// MULT/MULTU use shift-add and DIV/DIVU use restoring shift-subtract. Each
// produces one bit per clock and takes WIDTH iterations. MTHI/MTLO write
// HI/LO in a single cycle while the unit is idle.
//
// Ports:
//   Clk    - system clock, rising-edge active
//   Reset  - asynchronous, active-high reset
//   start  - request strobe, only sampled while idle
//   op     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//            110/111 no-op
//   inA    - rs operand (multiplicand / dividend / MTHI-MTLO data)
//   inB    - rt operand (multiplier / divisor)
//   busy   - high while an arithmetic operation is in flight
//   done   - one-cycle pulse when HI/LO receive an arithmetic result
//   hi, lo - HI and LO registers
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]      count;
    logic               is_div;      // operation in flight is a divide
    logic               a_neg;       // signed op with negative inA
    logic               b_neg;       // signed op with negative inB
    logic               div_zero;    // divide with a zero divisor
    logic [WIDTH-1:0]   a_orig;      // original dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]   opb;         // multiplicand or divisor magnitude
    logic [2*WIDTH:0]   acc;         // shared accumulator, one guard bit on top

    // Decode of the requested operation.
    logic req_arith;
    logic req_signed;
    logic req_div;

    assign req_arith  = start && (op[2] == 1'b0);
    assign req_signed = (op[0] == 1'b0);
    assign req_div    = op[1];

    // Conditional two's-complement negation; magnitude of a negative value
    // wraps correctly, so |32'h80000000| reads as 2**31 unsigned.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        cond_neg = neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
        cond_neg2 = neg ? (~v + 1'b1) : v;
    endfunction

    // One iteration of the shift-add multiply. The low half of acc starts as
    // the multiplier and is shifted out as product bits shift in from above.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_next;

    // One iteration of the restoring divide. The low half of acc starts as
    // the dividend and fills with quotient bits; the upper part is the
    // partial remainder.
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH:0]   div_next;

    always_comb begin
        mul_sum  = acc[2*WIDTH:WIDTH] + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
        mul_next = {1'b0, mul_sum, acc[WIDTH-1:1]};

        div_rem  = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_rem - {1'b0, opb};
        if (div_diff[WIDTH]) begin
            // Borrow: restore, quotient bit is 0.
            div_next = {acc[2*WIDTH-1:0], 1'b0};
        end else begin
            div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
        end
    end

    // Final sign-corrected results, consumed on the FIN edge.
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    always_comb begin
        product   = cond_neg2(acc[2*WIDTH-1:0], a_neg ^ b_neg);
        quotient  = cond_neg(acc[WIDTH-1:0], a_neg ^ b_neg);
        remainder = cond_neg(acc[2*WIDTH-1:WIDTH], a_neg);
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_arith) state_next = RUN;
            RUN:  if (count == LAST) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status outputs are registered from the next state so busy tracks the
    // state register exactly.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == FIN);
        end
    end

    // Operand capture and iteration.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count    <= '0;
            is_div   <= 1'b0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            div_zero <= 1'b0;
            a_orig   <= '0;
            opb      <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_arith) begin
                        count    <= '0;
                        is_div   <= req_div;
                        a_neg    <= req_signed && inA[WIDTH-1];
                        b_neg    <= req_signed && inB[WIDTH-1];
                        div_zero <= req_div && (inB == '0);
                        a_orig   <= inA;
                        if (req_div) begin
                            opb <= cond_neg(inB, req_signed && inB[WIDTH-1]);
                            acc <= {{(WIDTH+1){1'b0}},
                                    cond_neg(inA, req_signed && inA[WIDTH-1])};
                        end else begin
                            opb <= cond_neg(inA, req_signed && inA[WIDTH-1]);
                            acc <= {{(WIDTH+1){1'b0}},
                                    cond_neg(inB, req_signed && inB[WIDTH-1])};
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    acc   <= is_div ? div_next : mul_next;
                end
                default: ;
            endcase
        end
    end

    // HI/LO change only on an idle MTHI/MTLO or on the FIN edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == IDLE) begin
            if (start && op == 3'b100) hi <= inA;
            if (start && op == 3'b101) lo <= inA;
        end else if (state == FIN) begin
            if (!is_div) begin
                hi <= product[2*WIDTH-1:WIDTH];
                lo <= product[WIDTH-1:0];
            end else if (div_zero) begin
                hi <= a_orig;
                lo <= '1;
            end else begin
                hi <= remainder;
                lo <= quotient;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//
// Self-checking bench for hilo_muldiv_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  inA;
    logic [W-1:0]  inB;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] hi_m;
    logic [W-1:0] lo_m;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start),
        .op    (op),
        .inA   (inA),
        .inB   (inB),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference results from plain integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
        longint     sp, sq, sr;
        logic [63:0] up;
        h = hi_m;
        l = lo_m;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                h = sp[63:32];
                l = sp[31:0];
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                h = up[63:32];
                l = up[31:0];
            end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    l = 32'hFFFFFFFF;
                    h = a;
                end else if (o == 3'd2) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    l = sq[31:0];
                    h = sr[31:0];
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: ;
        endcase
    endtask

    // Single-cycle op (MTHI/MTLO/no-op) issued while idle.
    task automatic mt(input logic [2:0] o, input logic [31:0] a);
        @(negedge Clk);
        start = 1'b1;
        op    = o;
        inA   = a;
        inB   = $urandom;
        @(posedge Clk);
        #1;
        start = 1'b0;
        if (o == 3'd4) hi_m = a;
        if (o == 3'd5) lo_m = a;
        chk("mt_hi", 64'(hi), 64'(hi_m));
        chk("mt_lo", 64'(lo), 64'(lo_m));
        chk("mt_busy", 64'(busy), 64'd0);
        chk("mt_done", 64'(done), 64'd0);
    endtask

    // Arithmetic op. inj: busy cycle at which an MTLO 5 request is pulsed
    // (0 = none). rst_at: busy cycle at which Reset is asserted (0 = none).
    task automatic run_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input int inj, input int rst_at);
        logic [31:0] eh;
        logic [31:0] el;
        int n;
        bit fin;
        model(o, a, b, eh, el);
        @(negedge Clk);
        start = 1'b1;
        op    = o;
        inA   = a;
        inB   = b;
        @(posedge Clk);
        #1;
        start = 1'b0;
        inA   = $urandom;
        inB   = $urandom;
        op    = 3'($urandom);
        n   = 0;
        fin = 1'b0;
        for (int k = 0; k < 100 && !fin; k++) begin
            @(negedge Clk);
            if (busy) begin
                n++;
                if (n == inj) begin
                    start = 1'b1;
                    op    = 3'd5;
                    inA   = 32'd5;
                end else if (n < 30) begin
                    start = 1'($urandom_range(0, 1));
                    op    = 3'($urandom);
                    inA   = $urandom;
                end else begin
                    start = 1'b0;
                end
                if (n == rst_at) begin
                    start = 1'b0;
                    #2 Reset = 1'b1;
                    #1;
                    chk("rst_busy", 64'(busy), 64'd0);
                    chk("rst_done", 64'(done), 64'd0);
                    chk("rst_hi", 64'(hi), 64'd0);
                    chk("rst_lo", 64'(lo), 64'd0);
                    hi_m = '0;
                    lo_m = '0;
                    @(posedge Clk);
                    @(negedge Clk);
                    Reset = 1'b0;
                    for (int j = 0; j < 3; j++) begin
                        @(negedge Clk);
                        chk("rst_no_done", 64'(done), 64'd0);
                        chk("rst_no_busy", 64'(busy), 64'd0);
                    end
                    return;
                end
            end else begin
                fin = 1'b1;
                chk("busy_cycles", 64'(n), 64'd33);
                chk("done_pulse", 64'(done), 64'd1);
                chk("res_hi", 64'(hi), 64'(eh));
                chk("res_lo", 64'(lo), 64'(el));
                hi_m = eh;
                lo_m = el;
            end
        end
        if (!fin) chk("timeout", 64'd0, 64'd1);
        start = 1'b0;
        @(negedge Clk);
        chk("done_once", 64'(done), 64'd0);
        chk("hold_hi", 64'(hi), 64'(hi_m));
        chk("hold_lo", 64'(lo), 64'(lo_m));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: pick = 32'd0;
            1: pick = 32'd1;
            2: pick = 32'hFFFFFFFF;
            3: pick = 32'h80000000;
            4: pick = 32'h7FFFFFFF;
            5: pick = $urandom_range(0, 20);
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        inA   = '0;
        inB   = '0;
        hi_m  = '0;
        lo_m  = '0;
        repeat (3) @(negedge Clk);
        chk("init_hi", 64'(hi), 64'd0);
        chk("init_lo", 64'(lo), 64'd0);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_done", 64'(done), 64'd0);
        Reset = 1'b0;

        // Asynchronous reset between edges clears a written LO immediately.
        mt(3'd5, 32'h00001234);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("async_lo", 64'(lo), 64'd0);
        chk("async_hi", 64'(hi), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        hi_m = '0;
        lo_m = '0;
        @(negedge Clk);
        Reset = 1'b0;

        mt(3'd4, 32'hDEADBEEF);
        chk("mthi_const", 64'(hi), 64'h00000000DEADBEEF);
        mt(3'd6, 32'h11111111);
        mt(3'd7, 32'h22222222);

        run_arith(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        chk("multu_max", {32'(hi), 32'(lo)}, 64'hFFFFFFFE00000001);
        run_arith(3'd0, 32'hFFFFFFF9, 32'd6, 0, 0);
        chk("mult_neg", {32'(hi), 32'(lo)}, 64'hFFFFFFFFFFFFFFD6);
        run_arith(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
        chk("div_neg", {32'(hi), 32'(lo)}, 64'hFFFFFFFFFFFFFFFD);
        run_arith(3'd3, 32'd100, 32'd0, 0, 0);
        chk("divu_zero", {32'(hi), 32'(lo)}, 64'h00000064FFFFFFFF);
        run_arith(3'd2, 32'hFFFFFFF9, 32'd0, 0, 0);
        chk("div_zero", {32'(hi), 32'(lo)}, 64'hFFFFFFF9FFFFFFFF);
        run_arith(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        chk("div_ovf", {32'(hi), 32'(lo)}, 64'h0000000080000000);
        run_arith(3'd0, 32'h80000000, 32'h80000000, 0, 0);
        chk("mult_min", {32'(hi), 32'(lo)}, 64'h4000000000000000);
        run_arith(3'd3, 32'd100, 32'd7, 10, 0);
        chk("divu_inj", {32'(hi), 32'(lo)}, 64'h000000020000000E);
        run_arith(3'd0, 32'd3, 32'd4, 0, 20);
        run_arith(3'd1, 32'd3, 32'd4, 0, 0);
        chk("multu_after_rst", {32'(hi), 32'(lo)}, 64'h000000000000000C);

        for (int i = 0; i < 40; i++) begin
            run_arith(3'($urandom_range(0, 3)), pick(), pick(), 0, 0);
        end
        for (int i = 0; i < 10; i++) begin
            mt(3'($urandom_range(4, 7)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
